// File: rtl/grf_pkg.sv
// Register-file write-back definitions shared by the arbiter and its clients.
package grf_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_GRF_REGS = 32;
  localparam int unsigned GRF_DATA_W   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [GRF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: search starts at ptr and wraps, first asserted request wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // ptr + off stays below 2*NUM_REQ, so one conditional subtract is a full modulo
      idx = {1'b0, ptr} + (PTR_W+1)'(off);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin port sharing onto the register-file write port,
// plus a single-bit-per-register busy scoreboard for source hazard checks.
module wb_arbiter
  import grf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 wb_stall,
  input  logic                                 issue_valid,
  input  logic [REG_ADDR_W-1:0]                issue_addr,
  input  logic [1:0][REG_ADDR_W-1:0]           chk_addr,
  output logic [1:0]                           chk_busy,
  output logic                                 grf_we,
  output logic [REG_ADDR_W-1:0]                grf_wadd,
  output logic [DATA_W-1:0]                    grf_wdata
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [NUM_REQ-1:0]      grant;
  logic                    accept;
  logic [REG_ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]       sel_data;
  logic                    grf_we_d;
  logic [NUM_GRF_REGS-1:0] busy_q, busy_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Gating with reset keeps ready low while reset is held, independent of the clock.
  assign req_ready = grant & req_valid & {NUM_REQ{~wb_stall & reset}};
  assign accept    = |req_ready;

  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_idx  = PtrW'(i);
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (gnt_idx == PtrW'(NUM_REQ-1)) ? '0 : gnt_idx + PtrW'(1);
    end
    // Writes to r0 are consumed but never reach the register file.
    grf_we_d = accept && (sel_addr != '0);
  end

  // Clear first so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (grf_we) busy_d[grf_wadd] = 1'b0;
    if (issue_valid && (issue_addr != '0)) busy_d[issue_addr] = 1'b1;
  end

  always_comb begin
    chk_busy = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      chk_busy[k] = busy_q[chk_addr[k]] && (chk_addr[k] != '0) &&
                    !(grf_we && (grf_wadd == chk_addr[k]));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      busy_q    <= '0;
      grf_we    <= 1'b0;
      grf_wadd  <= '0;
      grf_wdata <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      grf_we   <= grf_we_d;
      if (grf_we_d) begin
        grf_wadd  <= sel_addr;
        grf_wdata <= sel_data;
      end
    end
  end

endmodule
